axi_ar_xbar_router: RTL

//  Parametrised AXI read-address (AR) channel router: NUM_M masters -> NUM_S slaves + 1 default slave.

---
 rtl/axi_ar_xbar_router.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/axi_ar_xbar_router.sv
// AXI read-address channel router: NUM_M masters onto NUM_S decoded slaves plus one default slave.
// Optional build macro AXI_AR_BACK2BACK_EN lets a new grant overlap the slave handshake cycle.
module axi_ar_xbar_router #(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3,
    parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {NUM_S{32'hFFFF_0000}}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_M*ID_W-1:0]             ARID_M,
    input  logic [NUM_M*ADDR_W-1:0]           ARADDR_M,
    input  logic [NUM_M*LEN_W-1:0]            ARLEN_M,
    input  logic [NUM_M*SIZE_W-1:0]           ARSIZE_M,
    input  logic [NUM_M*2-1:0]                ARBURST_M,
    input  logic [NUM_M-1:0]                  ARVALID_M,
    output logic [NUM_M-1:0]                  ARREADY_M,
    output logic [$clog2(NUM_M)+ID_W-1:0]     ARIDS_S,
    output logic [ADDR_W-1:0]                 ARADDR_S,
    output logic [LEN_W-1:0]                  ARLEN_S,
    output logic [SIZE_W-1:0]                 ARSIZE_S,
    output logic [1:0]                        ARBURST_S,
    output logic [NUM_S:0]                    ARVALID_S,
    input  logic [NUM_S:0]                    ARREADY_S
);

    localparam int MI_W  = $clog2(NUM_M);
    localparam int IDS_W = MI_W + ID_W;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [ID_W-1:0]   id_m    [NUM_M];
    logic [ADDR_W-1:0] addr_m  [NUM_M];
    logic [LEN_W-1:0]  len_m   [NUM_M];
    logic [SIZE_W-1:0] size_m  [NUM_M];
    logic [1:0]        burst_m [NUM_M];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_unpack
            assign id_m[gi]    = ARID_M[gi*ID_W +: ID_W];
            assign addr_m[gi]  = ARADDR_M[gi*ADDR_W +: ADDR_W];
            assign len_m[gi]   = ARLEN_M[gi*LEN_W +: LEN_W];
            assign size_m[gi]  = ARSIZE_M[gi*SIZE_W +: SIZE_W];
            assign burst_m[gi] = ARBURST_M[gi*2 +: 2];
        end
    endgenerate

    logic [0:0]        state_q, state_d;
    logic [MI_W-1:0]   ptr_q, ptr_d;
    logic [NUM_S:0]    arvalid_q, arvalid_d;
    logic [IDS_W-1:0]  ids_q, ids_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [1:0]        burst_q, burst_d;

    logic              handshake;
    logic              arb_en;
    logic              found;
    logic [MI_W-1:0]   win;
    logic [MI_W-1:0]   win_inc;
    logic [ADDR_W-1:0] addr_win;
    logic [NUM_S-1:0]  slv_hit;
    logic [NUM_S:0]    dest_oh;

    assign handshake = (state_q == SEND) && (|(arvalid_q & ARREADY_S));

`ifdef AXI_AR_BACK2BACK_EN
    assign arb_en = (state_q == IDLE) || handshake;
`else
    assign arb_en = (state_q == IDLE);
`endif

    // Round-robin scan starting at ptr_q, wrapping modulo NUM_M.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            idx = (int'(ptr_q) + k) % NUM_M;
            if (!found && ARVALID_M[idx]) begin
                found = 1'b1;
                win   = MI_W'(idx);
            end
        end
    end

    assign win_inc  = (win == MI_W'(NUM_M - 1)) ? '0 : win + 1'b1;
    assign addr_win = addr_m[win];

    generate
        for (gi = 0; gi < NUM_S; gi++) begin : g_dec
            localparam logic [ADDR_W-1:0] BASE_I = SLV_BASE[gi*ADDR_W +: ADDR_W];
            localparam logic [ADDR_W-1:0] MASK_I = SLV_MASK[gi*ADDR_W +: ADDR_W];
            assign slv_hit[gi] = ((addr_win & MASK_I) == (BASE_I & MASK_I));
        end
    endgenerate

    // Walking downward so the lowest matching slave is the last one written.
    always_comb begin
        dest_oh        = '0;
        dest_oh[NUM_S] = 1'b1;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if (slv_hit[i]) begin
                dest_oh    = '0;
                dest_oh[i] = 1'b1;
            end
        end
    end

    // Gated by rst so a master never sees a grant while the router is being reset.
    always_comb begin
        ARREADY_M = '0;
        if (!rst && arb_en && found) begin
            ARREADY_M[win] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        arvalid_d = arvalid_q;
        ids_d     = ids_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        if (handshake) begin
            state_d   = IDLE;
            arvalid_d = '0;
        end
        if (arb_en && found) begin
            state_d   = SEND;
            arvalid_d = dest_oh;
            ids_d     = {win, id_m[win]};
            addr_d    = addr_win;
            len_d     = len_m[win];
            size_d    = size_m[win];
            burst_d   = burst_m[win];
            ptr_d     = win_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            arvalid_q <= '0;
            ids_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            arvalid_q <= arvalid_d;
            ids_q     <= ids_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
        end
    end

    assign ARVALID_S = arvalid_q;
    assign ARIDS_S   = ids_q;
    assign ARADDR_S  = addr_q;
    assign ARLEN_S   = len_q;
    assign ARSIZE_S  = size_q;
    assign ARBURST_S = burst_q;

endmodule
